m_axis_fifo: RTL and testbench

Parametrised AXI4-Stream master source with an internal buffer and full backpressure support. It accepts words from the user datapath on a simple valid/ready port, buffers up to DEPTH beats, and presents them on an AXI-Stream master port that honours m_axis_tready. It sits between the processing core and the AXI DMA S2MM stream input. TLAST can be taken from the input stream or generated from a programmable packet length.

---
 rtl/m_axis_fifo.sv | 77 +++++++
 tb/tb_m_axis_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/m_axis_fifo.sv
// m_axis_fifo: buffered AXI4-Stream master with backpressure and a sticky overflow flag.
// Define M_AXIS_PKT_CNT_EN to generate tlast from pkt_len instead of passing in_last through.
module m_axis_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CNT_WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  input  logic [CNT_WIDTH-1:0]    pkt_len,
  output logic [AW:0]             level,
  output logic                    overflow
);
  logic [DATA_WIDTH:0] r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic r_ovf;
  logic w_empty, w_full, w_wr, w_rd, w_unused;
  logic [DATA_WIDTH:0] w_head;
  assign w_empty = r_wptr == r_rptr;
  assign w_full = r_wptr == {~r_rptr[AW], r_rptr[AW-1:0]};
  assign w_wr = in_valid && !w_full;
  assign w_rd = !w_empty && m_axis_tready;
  assign w_head = r_mem[r_rptr[AW-1:0]];
  assign in_ready = !w_full;
  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
  assign m_axis_tstrb = '1;
  assign level = r_wptr - r_rptr;
  assign overflow = r_ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      if (in_valid && w_full) r_ovf <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= {in_last, in_data};
  end
`ifdef M_AXIS_PKT_CNT_EN
  logic [CNT_WIDTH-1:0] r_cnt, r_len, w_len;
  logic r_lock;
  // length is frozen once a packet's first beat is on the bus, keeping tlast stable under stall
  assign w_len = r_lock ? r_len : (pkt_len == '0 ? CNT_WIDTH'(1) : pkt_len);
  assign m_axis_tlast = !w_empty && (r_cnt == w_len - 1'b1);
  assign w_unused = in_last ^ w_head[DATA_WIDTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_len <= '0;
      r_lock <= 1'b0;
    end else begin
      r_len <= w_len;
      if (w_rd) r_cnt <= m_axis_tlast ? '0 : r_cnt + 1'b1;
      if (w_rd && m_axis_tlast) r_lock <= 1'b0;
      else if (!w_empty) r_lock <= 1'b1;
    end
  end
`else
  assign m_axis_tlast = !w_empty && w_head[DATA_WIDTH];
  assign w_unused = ^pkt_len;
`endif
endmodule

// File: tb/tb_m_axis_fifo.sv
// tb_m_axis_fifo: queue-model checked bench for m_axis_fifo in either tlast mode.
module tb_m_axis_fifo;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  logic clk, rst, in_valid, in_last, in_ready, tvalid, tlast, tready, tr, tog_en, tog_bit, chk_en;
  logic [DW-1:0] in_data, tdata;
  logic [DW/8-1:0] tstrb;
  logic [15:0] pkt_len;
  logic [4:0] level;
  logic overflow;
  logic [DW:0] mq[$];
  logic [DW:0] got[$];
  logic m_ovf;
  int m_beat, m_len;
  int tests = 0, fails = 0;

  m_axis_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .m_axis_tvalid(tvalid), .m_axis_tdata(tdata), .m_axis_tstrb(tstrb),
    .m_axis_tlast(tlast), .m_axis_tready(tready), .pkt_len(pkt_len), .level(level),
    .overflow(overflow));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial tog_bit = 1'b1;
  always @(posedge clk) tog_bit <= ~tog_bit;
  assign tready = tog_en ? tog_bit : tr;

  function automatic int f_len();
    return m_beat != 0 ? m_len : (pkt_len == 0 ? 1 : int'(pkt_len));
  endfunction

  function automatic logic exp_last();
    if (mq.size() == 0) return 1'b0;
`ifdef M_AXIS_PKT_CNT_EN
    return m_beat == f_len() - 1;
`else
    return mq[0][DW];
`endif
  endfunction

  always @(posedge clk) begin : mdl
    automatic int n = mq.size();
    if (rst) begin
      mq.delete();
      m_ovf <= 1'b0;
      m_beat <= 0;
      m_len <= 1;
    end else begin
      if (in_valid && n == DEPTH) m_ovf <= 1'b1;
      if (n != 0 && tready) begin
        if (m_beat == 0) m_len <= f_len();
        m_beat <= exp_last() ? 0 : m_beat + 1;
        void'(mq.pop_front());
      end
      if (in_valid && n < DEPTH) mq.push_back({in_last, in_data});
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (chk_en && !rst) begin
      chk("tvalid", 64'(tvalid), 64'(mq.size() != 0));
      chk("tdata", 64'(tdata), mq.size() != 0 ? 64'(mq[0][DW-1:0]) : 64'd0);
      chk("tlast", 64'(tlast), 64'(exp_last()));
      chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
      chk("level", 64'(level), 64'(mq.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("tstrb", 64'(tstrb), 64'hf);
      if (tvalid && tready) got.push_back({tlast, tdata});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d, input logic l);
    for (int i = 0; i < 200 && !in_ready; i++) cyc();
    if (!in_ready) chk("wr_timeout", 64'd0, 64'd1);
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    tog_en = 1'b0;
    tr = 1'b1;
    for (int i = 0; i < 300 && mq.size() != 0; i++) cyc();
    chk("drain_level", 64'(level), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    pkt_len = 16'd0; tr = 1'b0; tog_en = 1'b0; chk_en = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_tstrb", 64'(tstrb), 64'hf);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    tr = 1'b1;
    got.delete();
    wr(32'h11, 1'b0);
    chk("lat_tvalid", 64'(tvalid), 64'd1);
    chk("lat_tdata", 64'(tdata), 64'h11);
    wr(32'h22, 1'b0);
    wr(32'h33, 1'b0);
    drain();
    chk("t1_count", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      chk("t1_b0", 64'(got[0][DW-1:0]), 64'h11);
      chk("t1_b1", 64'(got[1][DW-1:0]), 64'h22);
      chk("t1_b2", 64'(got[2][DW-1:0]), 64'h33);
    end
    tr = 1'b0;
    got.delete();
    for (int i = 0; i < 16; i++) wr(DW'(i), 1'b0);
    chk("full_level", 64'(level), 64'd16);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_data = 32'h99;
    cyc();
    in_valid = 1'b0;
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_level", 64'(level), 64'd16);
    drain();
    chk("t2_count", 64'(got.size()), 64'd16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("t2_data", 64'(got[i][DW-1:0]), 64'(i));
    got.delete();
    tog_en = 1'b1;
    for (int i = 0; i < 40; i++) wr(DW'(100 + i), i % 8 == 7);
    drain();
    chk("t3_count", 64'(got.size()), 64'd40);
    for (int i = 0; i < 40 && i < got.size(); i++) chk("t3_data", 64'(got[i][DW-1:0]), 64'(100 + i));
    got.delete();
    for (int i = 0; i < 5; i++) wr(DW'(32'h40 + i), i == 3);
    drain();
    chk("t4_count", 64'(got.size()), 64'd5);
`ifdef M_AXIS_PKT_CNT_EN
    for (int i = 0; i < 5 && i < got.size(); i++) chk("t4_last", 64'(got[i][DW]), 64'd1);
`else
    for (int i = 0; i < 5 && i < got.size(); i++) chk("t4_last", 64'(got[i][DW]), 64'(i == 3));
`endif
    pkt_len = 16'd3;
    got.delete();
    for (int i = 0; i < 9; i++) wr(DW'(32'h50 + i), i % 3 == 2);
    drain();
    chk("t5_count", 64'(got.size()), 64'd9);
    for (int i = 0; i < 9 && i < got.size(); i++) chk("t5_last", 64'(got[i][DW]), 64'(i % 3 == 2));
    pkt_len = 16'd0;
    got.delete();
    for (int i = 0; i < 3; i++) wr(DW'(32'h58 + i), 1'b1);
    drain();
    chk("t5z_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3 && i < got.size(); i++) chk("t5z_last", 64'(got[i][DW]), 64'd1);
    pkt_len = 16'd3;
    tr = 1'b0;
    for (int i = 0; i < 6; i++) wr(DW'(32'h60 + i), i % 3 == 2);
    tr = 1'b1;
    cyc();
    tr = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst2_tvalid", 64'(tvalid), 64'd0);
    chk("rst2_tdata", 64'(tdata), 64'd0);
    chk("rst2_level", 64'(level), 64'd0);
    chk("rst2_overflow", 64'(overflow), 64'd0);
    chk("rst2_in_ready", 64'(in_ready), 64'd1);
    got.delete();
    tr = 1'b1;
    for (int i = 0; i < 3; i++) wr(DW'(32'h70 + i), i == 2);
    drain();
    chk("t6_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      chk("t6_data", 64'(got[i][DW-1:0]), 64'(32'h70 + i));
      chk("t6_last", 64'(got[i][DW]), 64'(i == 2));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
